// File: rtl/fp_pkg.sv
// Shared types and constants for the BLS12-381 base-field arithmetic units.
package fp_pkg;

  localparam int DATA_W    = 381;
  localparam int LIMB_W    = 64;
  localparam int NUM_LIMBS = (DATA_W + LIMB_W - 1) / LIMB_W;
  localparam int EXT_W     = NUM_LIMBS * LIMB_W;
  localparam int IDX_W     = $clog2(NUM_LIMBS);

  typedef logic [DATA_W-1:0] fp_t;
  typedef logic [LIMB_W-1:0] limb_t;
  typedef logic [EXT_W-1:0]  ext_t;
  typedef logic [IDX_W-1:0]  idx_t;

  localparam fp_t MODULUS = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } sub_state_e;

  function automatic limb_t modulus_limb(input idx_t i);
    ext_t m;
    m = ext_t'(MODULUS);
    return limb_t'(m >> (LIMB_W * i));
  endfunction

endpackage

// File: rtl/fp_mod_sub_seq_limb_addsub.sv
// One-limb adder/subtractor with carry (add) or borrow (sub) in and out.
module limb_addsub
  import fp_pkg::*;
(
  input  logic  sub,
  input  limb_t x,
  input  limb_t y,
  input  logic  cin,
  output limb_t res,
  output logic  cout
);

  logic [LIMB_W:0] sum_s;
  limb_t           y_eff_s;
  logic            c_eff_s;

  // x - y - bin is x + ~y + !bin; the borrow out is the inverted carry
  always_comb begin
    if (sub) begin
      y_eff_s = ~y;
      c_eff_s = ~cin;
    end else begin
      y_eff_s = y;
      c_eff_s = cin;
    end
    sum_s = {1'b0, x} + {1'b0, y_eff_s} + {{LIMB_W{1'b0}}, c_eff_s};
    res   = sum_s[LIMB_W-1:0];
    if (sub) begin
      cout = ~sum_s[LIMB_W];
    end else begin
      cout = sum_s[LIMB_W];
    end
  end

endmodule

// File: rtl/fp_mod_sub_seq.sv
// Limb-serial (a - b) mod p: one subtract pass, then an optional +p pass
// when the difference underflows, both through a single shared limb datapath.
module fp_mod_sub_seq
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] r,
  output logic              corr
);

  localparam idx_t LAST_IDX = idx_t'(NUM_LIMBS - 1);

  sub_state_e state_q, state_d;
  idx_t       idx_q, idx_d;
  ext_t       a_q, a_d;
  ext_t       b_q, b_d;
  ext_t       r_q, r_d;
  logic       cy_q, cy_d;
  logic       corr_q, corr_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;

  logic  au_sub;
  limb_t au_x;
  limb_t au_y;
  limb_t au_res;
  logic  au_cout;

  limb_addsub u_limb (
    .sub  (au_sub),
    .x    (au_x),
    .y    (au_y),
    .cin  (cy_q),
    .res  (au_res),
    .cout (au_cout)
  );

  // Operands and result are shift registers: the low limb is always the one in flight
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cy_d    = cy_q;
    corr_d  = corr_q;
    au_sub  = 1'b1;
    au_x    = a_q[LIMB_W-1:0];
    au_y    = b_q[LIMB_W-1:0];

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = ext_t'(a);
          b_d     = ext_t'(b);
          cy_d    = 1'b0;
          idx_d   = '0;
          state_d = SUB;
        end else begin
          state_d = IDLE;
        end
      end
      SUB: begin
        r_d  = {au_res, r_q[EXT_W-1:LIMB_W]};
        a_d  = a_q >> LIMB_W;
        b_d  = b_q >> LIMB_W;
        cy_d = au_cout;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          cy_d  = 1'b0;
          if (au_cout) begin
            state_d = CORR;
          end else begin
            corr_d  = 1'b0;
            state_d = DONE;
          end
        end else begin
          idx_d = idx_q + idx_t'(1);
        end
      end
      CORR: begin
        au_sub = 1'b0;
        au_x   = r_q[LIMB_W-1:0];
        au_y   = modulus_limb(idx_q);
        r_d    = {au_res, r_q[EXT_W-1:LIMB_W]};
        cy_d   = au_cout;
        if (idx_q == LAST_IDX) begin
          // Top carry dropped: the sum wraps mod 2^EXT_W
          idx_d   = '0;
          cy_d    = 1'b0;
          corr_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + idx_t'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      cy_q        <= 1'b0;
      corr_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      cy_q        <= cy_d;
      corr_q      <= corr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r         = r_q[DATA_W-1:0];
  assign corr      = corr_q;

endmodule

// File: tb/tb_fp_mod_sub_seq.sv
// Scoreboard bench for fp_mod_sub_seq: expected results queued at accept, checked at out_valid.
module tb_fp_mod_sub_seq;
  import fp_pkg::*;

  typedef struct packed {
    fp_t  r;
    logic corr;
    int   lat;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] r;
  logic              corr;

  int   checks;
  int   errors;
  exp_t sb_q[$];

  localparam fp_t P_MINUS_2 = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaa9;

  fp_mod_sub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .corr      (corr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input fp_t ma, input fp_t mb);
    logic [383:0] t;
    exp_t e;
    t = {3'b000, ma} - {3'b000, mb};
    if (ma < mb) begin
      t = t + {3'b000, MODULUS};
      e.corr = 1'b1;
      e.lat  = 2 * NUM_LIMBS;
    end else begin
      e.corr = 1'b0;
      e.lat  = NUM_LIMBS;
    end
    e.r = t[DATA_W-1:0];
    return e;
  endfunction

  function automatic fp_t rand_fe();
    logic [383:0] t;
    fp_t v;
    for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
    v = t[DATA_W-1:0];
    if (v >= MODULUS) v = v - MODULUS;
    return v;
  endfunction

  task automatic start_op(input fp_t ta, input fp_t tb, input bit push);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 40) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
    end
    if (push) sb_q.push_back(model(ta, tb));
    a = ta;
    b = tb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = rand_fe();
    b = rand_fe();
  endtask

  task automatic finish_op(input int lat0);
    int lat;
    exp_t e;
    lat = lat0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: out_valid=%b with no expected entry", out_valid);
    end else if (out_valid !== 1'b1) begin
      void'(sb_q.pop_front());
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles", out_valid, lat);
    end else begin
      e = sb_q.pop_front();
      if (r !== e.r) begin
        errors++;
        $display("FAIL result: r=%h required %h", r, e.r);
      end
      checks++;
      if (corr !== e.corr) begin
        errors++;
        $display("FAIL corr: got %b required %b", corr, e.corr);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL latency: got %0d required %0d", lat, e.lat);
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL consume: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic run_op(input fp_t ta, input fp_t tb);
    start_op(ta, tb, 1'b1);
    finish_op(0);
    consume();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || r !== '0 || corr !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b corr=%b r=%h required 1/0/0/0",
               in_ready, out_valid, corr, r);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    fp_t tmp;
    run_op(381'd5, 381'd3);
    start_op(381'd3, 381'd5, 1'b1);
    finish_op(0);
    checks++;
    tmp = r;
    if (tmp !== P_MINUS_2) begin
      errors++;
      $display("FAIL p_minus_2_literal: r=%h required %h", tmp, P_MINUS_2);
    end
    consume();
  endtask

  task automatic test_edges();
    fp_t pm1;
    fp_t one64;
    pm1 = MODULUS - 381'd1;
    one64 = 381'd1 << 64;
    run_op(pm1, pm1);
    run_op(381'd0, pm1);
    run_op(pm1, 381'd0);
    run_op(one64, 381'd1);
  endtask

  task automatic test_backpressure();
    fp_t r_snap;
    logic c_snap;
    bit bad;
    start_op(381'd100, 381'd40, 1'b1);
    @(posedge clk); #1;
    a = 381'd1;
    b = 381'd999;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL in_ready_during_sub: got %b required 0", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish_op(2);
    r_snap = r;
    c_snap = corr;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || r !== r_snap || corr !== c_snap) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_stable: out_valid=%b in_ready=%b r=%h required 1/0/%h",
               out_valid, in_ready, r, r_snap);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    fp_t na;
    fp_t nb;
    na = rand_fe();
    nb = rand_fe();
    start_op(381'd9, 381'd20, 1'b1);
    finish_op(0);
    a = na;
    b = nb;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_overlap: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    sb_q.push_back(model(na, nb));
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: in_ready=%b required 0", in_ready);
    end
    finish_op(0);
    consume();
    for (int i = 0; i < 4; i++) run_op(rand_fe(), rand_fe());
  endtask

  task automatic test_reset_mid_corr();
    bit seen;
    start_op(381'd3, 381'd5, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || r !== '0 || corr !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_corr: in_ready=%b out_valid=%b corr=%b r=%h required 1/0/0/0",
               in_ready, out_valid, corr, r);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL aborted_result: out_valid=1 seen after reset, required 0");
    end
    run_op(381'd7, 381'd4);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_edges();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_corr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
